// File: rtl/rtype_decode_stage_if.sv
// Fetch, write-back and execute-side bus for rtype_decode_stage.
// slave = decode stage view, master = surrounding pipeline view.
interface rtype_decode_stage_if #(
  parameter int XLEN = 64
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic                   wb_en;
  logic [4:0]             wb_rd;
  logic [XLEN-1:0]        wb_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            instruction;
  logic signed [XLEN-1:0] reg1;
  logic signed [XLEN-1:0] reg2;
  logic [4:0]             rd;
  logic                   illegal;
  logic [31:0]            issue_cnt;

  modport slave (
    input  in_valid,
    input  in_instr,
    input  wb_en,
    input  wb_rd,
    input  wb_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output instruction,
    output reg1,
    output reg2,
    output rd,
    output illegal,
    output issue_cnt
  );

  modport master (
    output in_valid,
    output in_instr,
    output wb_en,
    output wb_rd,
    output wb_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  instruction,
    input  reg1,
    input  reg2,
    input  rd,
    input  illegal,
    input  issue_cnt
  );
endinterface

// File: rtl/rtype_decode_stage.sv
// RV64 R-type decode / operand fetch stage with owned 32x64 register file.
// Optional same-edge write bypass: define RTYPE_DECODE_BYPASS_EN.
module rtype_decode_stage #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rtype_decode_stage_if.slave  bus
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] F7_STD = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic            illegal;
  } pay_t;

  logic [XLEN-1:0] rf_q [NREG];

  pay_t        pay_q;
  pay_t        pay_d;
  logic        out_valid_q;
  logic        out_valid_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  logic            accept;
  logic            drain;
  logic            wr_hit;
  logic [4:0]      rs1_in;
  logic [4:0]      rs2_in;
  logic [4:0]      rs1_held;
  logic [4:0]      rs2_held;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  function automatic logic is_legal(
    input logic [31:0] i
  );
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = i[31:25];
    f3 = i[14:12];
    is_legal = 1'b0;
    if (i[6:0] == OP_R) begin
      unique case (1'b1)
        (f7 == F7_STD): is_legal = 1'b1;
        (f7 == F7_ALT): is_legal = (f3 == 3'b000)
                                || (f3 == 3'b101);
        default:        is_legal = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [XLEN-1:0] rf_read(
    input logic [4:0] a
  );
    rf_read = '0;
    if (a != 5'd0 && int'(a) < NREG)
      rf_read = rf_q[a];
  endfunction

  assign accept   = bus.in_valid && bus.in_ready;
  assign drain    = out_valid_q && bus.out_ready;
  assign wr_hit   = bus.wb_en && (bus.wb_rd != 5'd0);
  assign rs1_in   = bus.in_instr[19:15];
  assign rs2_in   = bus.in_instr[24:20];
  assign rs1_held = pay_q.instr[19:15];
  assign rs2_held = pay_q.instr[24:20];

  // Operand read; the bypass build forwards a same-edge write.
  always_comb begin
    rd1 = rf_read(rs1_in);
    rd2 = rf_read(rs2_in);
`ifdef RTYPE_DECODE_BYPASS_EN
    if (wr_hit && bus.wb_rd == rs1_in)
      rd1 = bus.wb_data;
    if (wr_hit && bus.wb_rd == rs2_in)
      rd2 = bus.wb_data;
`else
    rd1 = rd1;
    rd2 = rd2;
`endif
  end

  always_comb begin
    pay_d       = pay_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    if (drain) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + 32'd1;
    end
    if (accept) begin
      out_valid_d   = 1'b1;
      pay_d.instr   = bus.in_instr;
      pay_d.r1      = rd1;
      pay_d.r2      = rd2;
      pay_d.illegal = !is_legal(bus.in_instr);
    end else if (out_valid_q && !drain && wr_hit) begin
      // Stalled payload tracks late writes to its sources.
      if (bus.wb_rd == rs1_held)
        pay_d.r1 = bus.wb_data;
      if (bus.wb_rd == rs2_held)
        pay_d.r2 = bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pay_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      pay_q       <= pay_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++)
        rf_q[r] <= '0;
    end else if (wr_hit && int'(bus.wb_rd) < NREG) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  assign bus.in_ready    = !out_valid_q || bus.out_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.instruction = pay_q.instr;
  assign bus.reg1        = pay_q.r1;
  assign bus.reg2        = pay_q.r2;
  assign bus.rd          = pay_q.instr[11:7];
  assign bus.illegal     = pay_q.illegal;
  assign bus.issue_cnt   = cnt_q;

endmodule

// File: tb/tb_rtype_decode_stage.sv
// Directed self-checking bench for rtype_decode_stage.
// Expected values are hand-computed constants.
module tb_rtype_decode_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG90 = 64'hFFFF_FFFF_FFFF_FFA6;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  rtype_decode_stage_if #(.XLEN(64)) bus ();

  rtype_decode_stage #(.XLEN(64), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rt(
    input logic [6:0] f7,
    input logic [4:0] s2,
    input logic [4:0] s1,
    input logic [2:0] f3,
    input logic [4:0] d,
    input logic [6:0] op
  );
    rt = {f7, s2, s1, f3, d, op};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(
    input logic [4:0]  a,
    input logic [63:0] d
  );
    bus.wb_en   = 1'b1;
    bus.wb_rd   = a;
    bus.wb_data = d;
    step();
    bus.wb_en   = 1'b0;
  endtask

  logic [31:0] i_add;
  logic [31:0] i_sub;
  logic [31:0] i_sra;
  logic [31:0] i_stl;
  logic [31:0] i_x0;
  logic [31:0] i_bad1;
  logic [31:0] i_bad2;
  logic [31:0] i_and;
  logic [31:0] i_byp;
  logic [31:0] i_byp2;
  logic [31:0] i_rst;
  logic [63:0] exp_byp;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    i_add  = rt(7'h00, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011);
    i_sub  = rt(7'h20, 5'd3, 5'd2, 3'b000, 5'd4, 7'b0110011);
    i_sra  = rt(7'h20, 5'd3, 5'd2, 3'b101, 5'd5, 7'b0110011);
    i_stl  = rt(7'h00, 5'd3, 5'd5, 3'b000, 5'd6, 7'b0110011);
    i_x0   = rt(7'h00, 5'd3, 5'd0, 3'b000, 5'd7, 7'b0110011);
    i_bad1 = rt(7'h20, 5'd3, 5'd2, 3'b111, 5'd1, 7'b0110011);
    i_bad2 = rt(7'h00, 5'd2, 5'd3, 3'b000, 5'd1, 7'b0010011);
    i_and  = rt(7'h00, 5'd3, 5'd2, 3'b111, 5'd2, 7'b0110011);
    i_byp  = rt(7'h00, 5'd4, 5'd3, 3'b000, 5'd8, 7'b0110011);
    i_byp2 = rt(7'h00, 5'd4, 5'd3, 3'b000, 5'd9, 7'b0110011);
    i_rst  = rt(7'h00, 5'd3, 5'd2, 3'b000, 5'd10, 7'b0110011);
`ifdef RTYPE_DECODE_BYPASS_EN
    exp_byp = ONES;
`else
    exp_byp = 64'd30;
`endif

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_issue_cnt", 64'(bus.issue_cnt), 64'd0);
    chk("rst_instr", 64'(bus.instruction), 64'd0);
    chk("rst_reg1", bus.reg1, 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    wb(5'd2, MAXP);
    wb(5'd3, 64'd1);

    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = i_add;
    step();
    bus.in_valid  = 1'b0;
    chk("add_valid", 64'(bus.out_valid), 64'd1);
    chk("add_reg1", bus.reg1, MAXP);
    chk("add_reg2", bus.reg2, 64'd1);
    chk("add_rd", 64'(bus.rd), 64'd1);
    chk("add_illegal", 64'(bus.illegal), 64'd0);
    chk("add_instr", 64'(bus.instruction), 64'(i_add));
    chk("add_cnt0", 64'(bus.issue_cnt), 64'd0);
    step();
    chk("add_cnt1", 64'(bus.issue_cnt), 64'd1);
    chk("add_drained", 64'(bus.out_valid), 64'd0);

    bus.in_valid = 1'b1;
    bus.in_instr = i_sub;
    #1;
    chk("sub_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    chk("sub_instr", 64'(bus.instruction), 64'(i_sub));
    chk("sub_illegal", 64'(bus.illegal), 64'd0);
    chk("sub_in_ready2", 64'(bus.in_ready), 64'd1);
    bus.in_instr = i_sra;
    step();
    bus.in_valid = 1'b0;
    chk("sra_instr", 64'(bus.instruction), 64'(i_sra));
    chk("sra_valid", 64'(bus.out_valid), 64'd1);
    chk("sra_illegal", 64'(bus.illegal), 64'd0);
    chk("sra_rd", 64'(bus.rd), 64'd5);
    chk("b2b_cnt2", 64'(bus.issue_cnt), 64'd2);
    step();
    chk("b2b_cnt3", 64'(bus.issue_cnt), 64'd3);

    wb(5'd5, NEG90);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = i_stl;
    step();
    bus.in_valid  = 1'b0;
    bus.in_instr  = i_add;
    chk("stl_reg1_m90", bus.reg1, NEG90);
    chk("stl_in_ready0", 64'(bus.in_ready), 64'd0);
    wb(5'd5, 64'd40);
    chk("stl_reg1_40", bus.reg1, 64'd40);
    chk("stl_instr", 64'(bus.instruction), 64'(i_stl));
    chk("stl_in_ready1", 64'(bus.in_ready), 64'd0);
    chk("stl_reg2", bus.reg2, 64'd1);
    step();
    chk("stl_in_ready2", 64'(bus.in_ready), 64'd0);
    chk("stl_valid", 64'(bus.out_valid), 64'd1);
    chk("stl_cnt", 64'(bus.issue_cnt), 64'd3);
    bus.out_ready = 1'b1;
    #1;
    chk("stl_release", 64'(bus.in_ready), 64'd1);
    step();
    chk("stl_drained", 64'(bus.out_valid), 64'd0);
    chk("stl_cnt4", 64'(bus.issue_cnt), 64'd4);

    wb(5'd0, 64'hFFFF_0000_FFFF_0000);
    bus.in_valid = 1'b1;
    bus.in_instr = i_x0;
    step();
    bus.in_valid = 1'b0;
    chk("x0_reg1", bus.reg1, 64'd0);
    chk("x0_reg2", bus.reg2, 64'd1);
    step();
    chk("x0_cnt5", 64'(bus.issue_cnt), 64'd5);

    bus.in_valid = 1'b1;
    bus.in_instr = i_bad1;
    step();
    chk("bad1_illegal", 64'(bus.illegal), 64'd1);
    chk("bad1_reg1", bus.reg1, MAXP);
    chk("bad1_reg2", bus.reg2, 64'd1);
    chk("bad1_valid", 64'(bus.out_valid), 64'd1);
    bus.in_instr = i_bad2;
    step();
    chk("bad2_illegal", 64'(bus.illegal), 64'd1);
    chk("bad2_reg1", bus.reg1, 64'd1);
    chk("bad2_reg2", bus.reg2, MAXP);
    chk("bad2_cnt6", 64'(bus.issue_cnt), 64'd6);
    bus.in_instr = i_and;
    step();
    bus.in_valid = 1'b0;
    chk("and_illegal", 64'(bus.illegal), 64'd0);
    step();
    chk("ill_cnt8", 64'(bus.issue_cnt), 64'd8);

    wb(5'd4, 64'd30);
    bus.in_valid = 1'b1;
    bus.in_instr = i_byp;
    bus.wb_en    = 1'b1;
    bus.wb_rd    = 5'd4;
    bus.wb_data  = ONES;
    step();
    bus.wb_en    = 1'b0;
    bus.in_valid = 1'b0;
    chk("same_edge_reg2", bus.reg2, exp_byp);
    chk("same_edge_reg1", bus.reg1, 64'd1);
    step();
    bus.in_valid = 1'b1;
    bus.in_instr = i_byp2;
    step();
    bus.in_valid = 1'b0;
    chk("rf_after_write", bus.reg2, ONES);
    step();
    chk("byp_cnt10", 64'(bus.issue_cnt), 64'd10);

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = i_rst;
    step();
    bus.in_valid  = 1'b0;
    chk("mid_valid", 64'(bus.out_valid), 64'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_cnt", 64'(bus.issue_cnt), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_instr", 64'(bus.instruction), 64'd0);
    chk("arst_reg1", bus.reg1, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_cnt", 64'(bus.issue_cnt), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = i_rst;
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_rf1", bus.reg1, 64'd0);
    chk("post_rst_rf2", bus.reg2, 64'd0);
    chk("post_rst_rd", 64'(bus.rd), 64'd10);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
